// File: rtl/ahb_multi_slave_interconnect_pkg.sv
// Shared AHB definitions for the multi-slave interconnect.
// Contents: HTRANS/HRESP encodings, default region base/mask constants and
// packers for them, the default-slave state type, the data-phase record and
// the "transfer is active" helper.
package ahb_multi_slave_interconnect_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int MAX_SLAVES = 16;
  localparam int MAX_PACK_W = 1024;  // 16 slaves x up to 64-bit address

  localparam logic [31:0] DFLT_BASE   = 32'h3000_0000;
  localparam logic [31:0] DFLT_STRIDE = 32'h0001_0000;
  localparam logic [31:0] DFLT_MASK   = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // Data-phase record captured at the end of every address phase.
  typedef struct packed {
    logic [3:0] idx;   // selected slave
    logic       dflt;  // no slave matched: default slave owns the data phase
    logic       act;   // captured HTRANS was NONSEQ/SEQ
  } dphase_t;

  function automatic logic trans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

  // Slave i lives at DFLT_BASE + i*DFLT_STRIDE, packed at bit i*aw.
  function automatic logic [MAX_PACK_W-1:0] dflt_base_pack(input int n, input int aw);
    logic [MAX_PACK_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r |= MAX_PACK_W'(DFLT_BASE + DFLT_STRIDE * 32'(i)) << (i * aw);
    return r;
  endfunction

  function automatic logic [MAX_PACK_W-1:0] dflt_mask_pack(input int n, input int aw);
    logic [MAX_PACK_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r |= MAX_PACK_W'(DFLT_MASK) << (i * aw);
    return r;
  endfunction

endpackage

// File: rtl/ahb_multi_slave_interconnect_default_slave.sv
// Default slave: answers data phases that no real slave claimed.
// Active transfers receive the two-cycle AHB ERROR response; err_cnt counts
// each ERROR response (saturating).
// Ports:
//   HCLK, HRESETn   clock, async active-low reset
//   start           an active unmatched transfer is being captured this edge
//   hready, hresp   default-slave response for the current data phase
//   err_cnt         saturating ERROR response count
module ahb_default_slave
  import ahb_multi_slave_interconnect_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  output logic        hready,
  output logic        hresp,
  output logic [15:0] err_cnt
);

  ds_state_e state_q, state_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (start) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = start ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin hready = 1'b0; hresp = HRESP_ERROR; end
      DS_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // ERR1 is never re-entered from itself, so one increment per error.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      err_cnt <= '0;
    else if (state_d == DS_ERR1 && state_q != DS_ERR1 && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end

endmodule

// File: rtl/ahb_multi_slave_interconnect.sv
// Single-master AHB interconnect to NUM_SLAVES slaves plus a default slave.
// Address phase: combinational decode (or external one-hot select) drives
// HSEL_s. Data phase: a registered record selects which slave's response is
// muxed back to the master; unmatched transfers go to the default slave.
// Ports:
//   HCLK, HRESETn                clock, async active-low reset
//   HADDR, HTRANS                master address-phase signals
//   ext_hsel                     external one-hot select (SEL_MODE=1)
//   HSEL_s                       per-slave select
//   HRDATA_s, HREADYOUT_s, HRESP_s  slave responses (packed per slave)
//   HRDATA, HREADY, HRESP        muxed response; HREADY also goes to slaves
//   err_cnt                      default-slave ERROR count
module ahb_multi_slave_interconnect
  import ahb_multi_slave_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    (NUM_SLAVES*ADDR_W)'(dflt_base_pack(NUM_SLAVES, ADDR_W)),
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    (NUM_SLAVES*ADDR_W)'(dflt_mask_pack(NUM_SLAVES, ADDR_W)),
  parameter int SEL_MODE   = 0
)(
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic [NUM_SLAVES-1:0]        ext_hsel,
  output logic [NUM_SLAVES-1:0]        HSEL_s,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_s,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_s,
  input  logic [NUM_SLAVES-1:0]        HRESP_s,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [15:0]                  err_cnt
);

  logic [NUM_SLAVES-1:0] match, req;
  logic                  sel_hit;
  logic [3:0]            sel_idx;
  dphase_t               dp_q;
  logic                  ds_start, ds_hready, ds_hresp;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
    assign match[g] = (HADDR & SLV_MASK[g*ADDR_W +: ADDR_W]) == SLV_BASE[g*ADDR_W +: ADDR_W];
  end

  assign req = (SEL_MODE == 1) ? ext_hsel : match;

  // Lowest requesting index wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_hit = 1'b1;
        sel_idx = 4'(i);
      end
    end
  end

  always_comb begin
    HSEL_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      HSEL_s[i] = sel_hit && (sel_idx == 4'(i));
  end

  // Capture only when the shared HREADY completes the current data phase,
  // so a stalling slave holds off every new address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      dp_q <= '{idx: 4'd0, dflt: 1'b1, act: 1'b0};
    else if (HREADY)
      dp_q <= '{idx: sel_idx, dflt: !sel_hit, act: trans_active(HTRANS)};
  end

  assign ds_start = HREADY && !sel_hit && trans_active(HTRANS);

  ahb_default_slave u_dflt (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .start   (ds_start),
    .hready  (ds_hready),
    .hresp   (ds_hresp),
    .err_cnt (err_cnt)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    if (dp_q.dflt) begin
      if (dp_q.act) begin
        HREADY = ds_hready;
        HRESP  = ds_hresp;
      end
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dp_q.idx == 4'(i)) begin
          HRDATA = HRDATA_s[i*DATA_W +: DATA_W];
          HREADY = HREADYOUT_s[i];
          HRESP  = HRESP_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_multi_slave_interconnect.sv
// Bench for ahb_multi_slave_interconnect: directed scenarios followed by a
// randomized run, checked cycle by cycle against a transfer-level model.
// A second instance in external-select mode gets directed checks.
module tb_ahb_multi_slave_interconnect;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [NS-1:0] ext0, ext1;
  logic [NS*DW-1:0] rdata_s;
  logic [NS-1:0] rdy_s, resp_s;
  logic [NS-1:0] hsel0, hsel1;
  logic [DW-1:0] hrdata0, hrdata1;
  logic          hready0, hready1, hresp0, hresp1;
  logic [15:0]   cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  // Model: who owns the data phase (-1 = default slave), whether it was an
  // active transfer, which ERROR cycle we are in (0 none, 1 first, 2 second),
  // and the running error count.
  int m_slave, m_phase, m_cnt;
  bit m_act, m_rdy_exp;

  always #5 HCLK = ~HCLK;

  ahb_multi_slave_interconnect #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_MODE(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans), .ext_hsel(ext0),
    .HSEL_s(hsel0), .HRDATA_s(rdata_s), .HREADYOUT_s(rdy_s), .HRESP_s(resp_s),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0), .err_cnt(cnt0));

  ahb_multi_slave_interconnect #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_MODE(1)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans), .ext_hsel(ext1),
    .HSEL_s(hsel1), .HRDATA_s(rdata_s), .HREADYOUT_s(rdy_s), .HRESP_s(resp_s),
    .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1), .err_cnt(cnt1));

  // Memory map: four 64 KiB windows starting at 0x3000_0000.
  function automatic int ref_dec(input logic [31:0] a);
    if (a >= 32'h3000_0000 && a < 32'h3004_0000) return int'((a - 32'h3000_0000) >> 16);
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut0(input string tag);
    logic [31:0] ed;
    logic er, ep;
    int s;
    s = ref_dec(haddr);
    chk({tag, "_hsel"}, 64'(hsel0), (s < 0) ? 64'd0 : (64'd1 << s));
    if (m_slave >= 0) begin
      ed = rdata_s[m_slave*DW +: DW];
      er = rdy_s[m_slave];
      ep = resp_s[m_slave];
    end else begin
      ed = '0;
      er = (m_phase != 1);
      ep = (m_phase != 0);
    end
    m_rdy_exp = er;
    chk({tag, "_hrdata"}, 64'(hrdata0), 64'(ed));
    chk({tag, "_hready"}, 64'(hready0), 64'(er));
    chk({tag, "_hresp"},  64'(hresp0),  64'(ep));
    chk({tag, "_errcnt"}, 64'(cnt0),    64'(m_cnt));
  endtask

  // One bus cycle: check before the edge, advance the model at the edge.
  task automatic cyc(input string tag);
    #2;
    check_dut0(tag);
    @(posedge HCLK);
    if (m_rdy_exp) begin
      m_slave = ref_dec(haddr);
      m_act   = (htrans == 2'b10) || (htrans == 2'b11);
      if (m_slave < 0 && m_act) begin
        m_phase = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_phase = 0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    #1;
    m_slave = -1; m_act = 1'b0; m_phase = 0; m_cnt = 0;
    chk("rst_hready", 64'(hready0), 64'd1);
    chk("rst_hresp",  64'(hresp0),  64'd0);
    chk("rst_hrdata", 64'(hrdata0), 64'd0);
    chk("rst_errcnt", 64'(cnt0),    64'd0);
    chk("rst1_hready", 64'(hready1), 64'd1);
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b1;
    haddr = '0; htrans = 2'b00; ext0 = '0; ext1 = '0;
    rdy_s = '1; resp_s = '0;
    for (int i = 0; i < NS; i++) rdata_s[i*DW +: DW] = $urandom;
    @(posedge HCLK); #1;
    do_reset();
    cyc("post_rst");

    // Read from slave1
    rdata_s[1*DW +: DW] = 32'hDEAD_BEEF;
    haddr = 32'h3001_0004; htrans = 2'b10;
    #1 chk("r25_hsel", 64'(hsel0), 64'b0010);
    cyc("r25_a");
    haddr = '0; htrans = 2'b00;
    #1 chk("r25_data", 64'(hrdata0), 64'hDEAD_BEEF);
    cyc("r25_d");

    // Slave2 wait states stall the following slave0 address phase
    haddr = 32'h3002_0000; htrans = 2'b10;
    cyc("r26_a");
    haddr = 32'h3000_0010; htrans = 2'b10; rdy_s[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("r26_wait", 64'(hready0), 64'd0);
      cyc("r26_w");
    end
    rdy_s[2] = 1'b1;
    cyc("r26_rel");
    haddr = '0; htrans = 2'b00; rdata_s[0 +: DW] = 32'h0BAD_F00D;
    #1 chk("r26_s0data", 64'(hrdata0), 64'h0BAD_F00D);
    cyc("r26_d");

    // Unmatched address -> two-cycle ERROR
    haddr = 32'h5000_0000; htrans = 2'b10;
    #1 chk("r27_hsel", 64'(hsel0), 64'd0);
    cyc("r27_a");
    haddr = '0; htrans = 2'b00;
    #1 chk("r27_e1", 64'({hready0, hresp0}), 64'b01);
    cyc("r27_e1");
    #1 chk("r27_e2", 64'({hready0, hresp0}), 64'b11);
    chk("r27_cnt", 64'(cnt0), 64'd1);
    cyc("r27_e2");
    cyc("r27_idle");

    // Back-to-back slave0 then slave3
    haddr = 32'h3000_0000; htrans = 2'b10; cyc("r28_s0");
    haddr = 32'h3003_0000; htrans = 2'b11; rdata_s[0 +: DW] = 32'h1111_0000;
    #1 chk("r28_d0", 64'(hrdata0), 64'h1111_0000);
    cyc("r28_s3");
    haddr = '0; htrans = 2'b00; rdata_s[3*DW +: DW] = 32'h3333_0003;
    #1 chk("r28_d3", 64'(hrdata0), 64'h3333_0003);
    cyc("r28_d");

    // Reset during ERR1
    haddr = 32'h5000_0000; htrans = 2'b10; cyc("r30_a");
    haddr = 32'h3000_0000; htrans = 2'b00;
    #1 chk("r30_err1", 64'(hready0), 64'd0);
    do_reset();
    cyc("r30_post");
    cyc("r30_post2");

    // External select instance
    ext1 = 4'b0110; haddr = 32'h5000_0000; htrans = 2'b10; rdata_s[1*DW +: DW] = 32'hCAFE_0001;
    #1 chk("r29_hsel", 64'(hsel1), 64'b0010);
    cyc("r29_a");
    ext1 = 4'b0000; haddr = '0; htrans = 2'b10;
    #1 chk("r29_hsel0", 64'(hsel1), 64'd0);
    chk("r29_data", 64'({hrdata1, hready1, hresp1}), {30'd0, 32'hCAFE_0001, 2'b10});
    cyc("r29_b");
    htrans = 2'b00;
    #1 chk("r29_e1", 64'({hready1, hresp1}), 64'b01);
    cyc("r29_c");
    #1 chk("r29_e2", 64'({hready1, hresp1}), 64'b11);
    cyc("r29_d");
    #1 chk("r29_ok", 64'({hready1, hresp1}), 64'b10);
    chk("r29_cnt", 64'(cnt1), 64'd1);
    cyc("r29_e");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 4));
      if (r == 4) haddr = ($urandom_range(0, 1) == 0) ? (32'h5000_0000 | 32'($urandom_range(0, 255))) : 32'($urandom);
      else        haddr = 32'h3000_0000 + (32'(r) << 16) + 32'($urandom_range(0, 16'hFFFF));
      htrans = 2'($urandom_range(0, 3));
      rdy_s  = 4'($urandom) | 4'($urandom);
      resp_s = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int i = 0; i < NS; i++) rdata_s[i*DW +: DW] = $urandom;
      ext1 = 4'($urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_multi_slave_interconnect.md
AHB_MULTI_SLAVE_INTERCONNECT -- requirements
Module: ahb_multi_slave_interconnect

Interface
REQ-001 SHALL expose parameter NUM_SLAVES, default 4, number of slave ports (1..16).
REQ-002 SHALL expose parameter ADDR_W, default 32, HADDR width.
REQ-003 SHALL expose parameter DATA_W, default 32, HWDATA/HRDATA width.
REQ-004 SHALL expose parameter SLV_BASE, default {32'h3000_0000 + i*32'h0001_0000}, packed NUM_SLAVES*ADDR_W region bases.
REQ-005 SHALL expose parameter SLV_MASK, default all 32'hFFFF_0000, packed NUM_SLAVES*ADDR_W compare masks.
REQ-006 SHALL expose parameter SEL_MODE, default 0, 0 = address decode, 1 = external select via ext_hsel.
REQ-007 Ports, one clock; reset is asynchronous and active-low:
 HCLK  in  1  system clock, all state on rising edge
 HRESETn  in  1  asynchronous active-low reset
 HADDR  in  ADDR_W  master address
 HTRANS  in  2  master transfer type
 ext_hsel  in  NUM_SLAVES  external one-hot select, used when SEL_MODE=1
 HSEL_s  out  NUM_SLAVES  per-slave select
 HRDATA_s  in  NUM_SLAVES*DATA_W  slave read data
 HREADYOUT_s  in  NUM_SLAVES  slave ready
 HRESP_s  in  NUM_SLAVES  slave response (1 = ERROR)
 HRDATA  out  DATA_W  muxed read data to master
 HREADY  out  1  muxed ready, also fed back to all slaves
 HRESP  out  1  muxed response
 err_cnt  out  16  saturating count of default-slave ERROR responses

Function
REQ-008 Slave i matches when (HADDR & SLV_MASK[i]) == SLV_BASE[i]; with several matches, lowest index SHALL win.
REQ-009 SEL_MODE=1: the lowest set bit of ext_hsel SHALL select; ext_hsel==0 selects the default slave.
REQ-010 HSEL_s SHALL be combinational, one-hot or zero, and asserted only for the selected slave; it SHALL be independent of HTRANS.
REQ-011 Data-phase select register SHALL load {slave index, default flag, active flag} on every rising edge where HREADY=1; it SHALL hold while HREADY=0.
REQ-012 active flag SHALL be 1 when the captured HTRANS is NONSEQ(2'b10) or SEQ(2'b11).
REQ-013 Data phase on a real slave: HRDATA, HREADY, HRESP SHALL equal that slave's HRDATA_s, HREADYOUT_s, HRESP_s, with zero added latency.
REQ-014 Default slave, inactive (IDLE/BUSY): HREADY=1, HRESP=0, HRDATA=0 in the same cycle.
REQ-015 Default slave, active: two-cycle ERROR. Cycle 1 HREADY=0 HRESP=1; cycle 2 HREADY=1 HRESP=1; HRDATA=0 throughout.
REQ-016 Default-slave FSM states: IDLE, ERR1, ERR2. IDLE->ERR1 on capture of an active unmatched transfer; ERR1->ERR2 unconditionally; ERR2->ERR1 if a new active unmatched transfer is captured, otherwise ERR2->IDLE.
REQ-017 Back-to-back transfers to different slaves SHALL switch the response mux exactly at the data-phase boundary, with no bubble.
REQ-018 err_cnt SHALL increment by 1 on each ERR1 entry and saturate at 16'hFFFF, with no wrap.
REQ-019 Wait states from a slave SHALL stall address-phase capture for all slaves, since HREADY is shared.

Reset
REQ-020 HRESETn=0 SHALL asynchronously clear the data-phase register to default/inactive, set the FSM to IDLE, and clear err_cnt to 0.
REQ-021 During and directly after reset, outputs SHALL be HREADY=1, HRESP=0, HRDATA=0.
REQ-022 Reset asserted mid-transfer, including in ERR1, SHALL abort the transfer; the first post-reset cycle is an OKAY zero-wait data phase.

Structure
REQ-023 HTRANS/HRESP encodings and default base/mask constants SHALL reside in the shared AHB header/package, not in the module.
REQ-024 The default-slave FSM and err_cnt SHALL be a sub-module, ahb_default_slave; decode and mux stay in the top module.

Verification
REQ-025 NONSEQ read to 0x3001_0004 with slave1 HRDATA_s=0xDEAD_BEEF -> HSEL_s=4'b0010; next cycle HRDATA=0xDEAD_BEEF, HREADY=1, HRESP=0.
REQ-026 Slave2 holds HREADYOUT_s=0 for 3 cycles -> HREADY low for 3 cycles and the next address phase is not captured until release.
REQ-027 NONSEQ to 0x5000_0000 (unmatched) -> HSEL_s=0, then HREADY=0/HRESP=1 followed by HREADY=1/HRESP=1; err_cnt 0->1.
REQ-028 Back-to-back writes to slave0 then slave3 -> response mux follows each data phase with no idle cycle.
REQ-029 SEL_MODE=1, ext_hsel=4'b0110 -> slave1 selected regardless of HADDR; ext_hsel=0 with NONSEQ -> ERROR sequence.
REQ-030 HRESETn pulsed low during ERR1 -> HREADY=1, HRESP=0, err_cnt=0 immediately; next IDLE transfer completes OKAY.
